lsq_fifo: RTL and testbench

- Program-ordered load/store queue. Entries are allocated at dispatch and filled in place by the AGU (address) and by CDB snoop (store data).
- Presents its head entry to the memory controller as head_load, head_ready and mem_out.
- Dequeues the head when the memory controller pulses rd_en.
- Sits between dispatch/AGU/CDB and the memory controller; it is the producer end of the LSQ→memory interface.

---
 rtl/lsq_fifo.sv | 156 +++++++++++++++
 tb/tb_lsq_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_fifo.sv
// Program-ordered load/store queue: dispatch allocates, AGU/CDB fill in place, memory side drains the head.
// Define LSQ_FULL_ALLOC_EN to let a full queue accept an allocation in the same cycle as a dequeue.

typedef struct packed {
  logic [31:0] address;
  logic [31:0] result;
  logic [3:0]  ROB_entry;
} lsq_packet_t;

module lsq_fifo #(
  parameter int DEPTH     = 8,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic                 alloc_is_load,
  input  logic [ROB_IDX_W-1:0] alloc_rob_entry,
  input  logic                 alloc_data_ready,
  input  logic [31:0]          alloc_data,
  input  logic [ROB_IDX_W-1:0] alloc_data_tag,
  output logic                 alloc_ready,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic                 agu_valid,
  input  logic [IDX_W-1:0]     agu_idx,
  input  logic [31:0]          agu_address,
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_rob_entry,
  input  logic [31:0]          cdb_result,
  input  logic                 flush,
  input  logic                 rd_en,
  output logic                 head_load,
  output logic                 head_ready,
  output lsq_packet_t          mem_out,
  output logic [IDX_W:0]       count
);

  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]     head_ptr;
  logic [PTR_W-1:0]     tail_ptr;
  logic [IDX_W-1:0]     head_idx;
  logic [IDX_W-1:0]     tail_idx;
  logic                 empty;
  logic                 full;

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     is_load;
  logic [DEPTH-1:0]     addr_valid;
  logic [DEPTH-1:0]     data_valid;
  logic [31:0]          addr_mem [DEPTH];
  logic [31:0]          data_mem [DEPTH];
  logic [ROB_IDX_W-1:0] rob_mem  [DEPTH];
  logic [ROB_IDX_W-1:0] tag_mem  [DEPTH];

  logic                 alloc_fire;
  logic                 deq_fire;
  logic                 agu_fire;
  logic                 alloc_cdb_hit;
  logic                 alloc_data_valid;
  logic [DEPTH-1:0]     snoop_hit;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign empty    = (head_ptr == tail_ptr);
  assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

`ifdef LSQ_FULL_ALLOC_EN
  assign alloc_ready = !full || rd_en;
`else
  assign alloc_ready = !full;
`endif

  assign alloc_idx = tail_idx;
  assign count     = tail_ptr - head_ptr;

  // Flush discards every other update made in the same cycle.
  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign deq_fire   = rd_en && !empty && !flush;
  assign agu_fire   = agu_valid && valid[agu_idx] && !flush;

  assign alloc_cdb_hit    = cdb_valid && !alloc_is_load && !alloc_data_ready &&
                            (alloc_data_tag == cdb_rob_entry);
  assign alloc_data_valid = alloc_is_load || alloc_data_ready || alloc_cdb_hit;

  always_comb begin
    snoop_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop_hit[i] = cdb_valid && valid[i] && !is_load[i] && !data_valid[i] &&
                     (tag_mem[i] == cdb_rob_entry);
    end
  end

  // Control state; allocation is written last so it owns a slot freed by a same-cycle dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      valid      <= '0;
      is_load    <= '0;
      addr_valid <= '0;
      data_valid <= '0;
    end else if (flush) begin
      valid    <= '0;
      tail_ptr <= head_ptr;
    end else begin
      data_valid <= data_valid | snoop_hit;
      if (agu_fire) begin
        addr_valid[agu_idx] <= 1'b1;
      end
      if (deq_fire) begin
        valid[head_idx] <= 1'b0;
        head_ptr        <= head_ptr + PTR_W'(1);
      end
      if (alloc_fire) begin
        valid[tail_idx]      <= 1'b1;
        is_load[tail_idx]    <= alloc_is_load;
        addr_valid[tail_idx] <= 1'b0;
        data_valid[tail_idx] <= alloc_data_valid;
        tail_ptr             <= tail_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (snoop_hit[i]) begin
          data_mem[i] <= cdb_result;
        end
      end
      if (agu_fire) begin
        addr_mem[agu_idx] <= agu_address;
      end
      if (alloc_fire) begin
        rob_mem[tail_idx]  <= alloc_rob_entry;
        tag_mem[tail_idx]  <= alloc_data_tag;
        data_mem[tail_idx] <= alloc_cdb_hit ? cdb_result : alloc_data;
      end
    end
  end

  assign head_load  = valid[head_idx] && is_load[head_idx];
  assign head_ready = valid[head_idx] && addr_valid[head_idx] && data_valid[head_idx];

  always_comb begin
    mem_out = '0;
    if (!empty) begin
      mem_out.address   = addr_mem[head_idx];
      mem_out.result    = data_mem[head_idx];
      mem_out.ROB_entry = rob_mem[head_idx];
    end
  end

endmodule

// File: tb/tb_lsq_fifo.sv
// Randomized bench for lsq_fifo against a queue-based reference model.
// Honours LSQ_FULL_ALLOC_EN when predicting alloc_ready on a full queue.

module tb_lsq_fifo;

  localparam int DEPTH     = 8;
  localparam int IDX_W     = 3;
  localparam int ROB_IDX_W = 4;

`ifdef LSQ_FULL_ALLOC_EN
  localparam bit FULL_EN = 1'b1;
`else
  localparam bit FULL_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 alloc_valid;
  logic                 alloc_is_load;
  logic [ROB_IDX_W-1:0] alloc_rob_entry;
  logic                 alloc_data_ready;
  logic [31:0]          alloc_data;
  logic [ROB_IDX_W-1:0] alloc_data_tag;
  logic                 alloc_ready;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 agu_valid;
  logic [IDX_W-1:0]     agu_idx;
  logic [31:0]          agu_address;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_entry;
  logic [31:0]          cdb_result;
  logic                 flush;
  logic                 rd_en;
  logic                 head_load;
  logic                 head_ready;
  lsq_packet_t          mem_out;
  logic [IDX_W:0]       count;

  lsq_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_is_load(alloc_is_load),
    .alloc_rob_entry(alloc_rob_entry), .alloc_data_ready(alloc_data_ready),
    .alloc_data(alloc_data), .alloc_data_tag(alloc_data_tag),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_address(agu_address),
    .cdb_valid(cdb_valid), .cdb_rob_entry(cdb_rob_entry), .cdb_result(cdb_result),
    .flush(flush), .rd_en(rd_en),
    .head_load(head_load), .head_ready(head_ready), .mem_out(mem_out), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [3:0]  rob;
    bit          addr_valid;
    logic [31:0] address;
    bit          data_valid;
    logic [31:0] data;
    logic [3:0]  data_tag;
  } entry_t;

  // Reference model: queue in program order; slot of q[k] is (head_slot + k) mod DEPTH.
  entry_t q[$];
  int     head_slot = 0;
  int     total = 0;
  int     bad = 0;

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IDX_W-1:0] next_slot();
    return IDX_W'((head_slot + q.size()) % DEPTH);
  endfunction

  task automatic idle_inputs();
    alloc_valid      = 1'b0;
    alloc_is_load    = 1'b0;
    alloc_rob_entry  = '0;
    alloc_data_ready = 1'b0;
    alloc_data       = '0;
    alloc_data_tag   = '0;
    agu_valid        = 1'b0;
    agu_idx          = '0;
    agu_address      = '0;
    cdb_valid        = 1'b0;
    cdb_rob_entry    = '0;
    cdb_result       = '0;
    flush            = 1'b0;
    rd_en            = 1'b0;
  endtask

  task automatic model_check();
    int n;
    bit exp_ready;
    n = q.size();
    exp_ready = (n < DEPTH) || (FULL_EN && rd_en);
    checkOutput("count", 80'(count), 80'(n));
    checkOutput("alloc_ready", 80'(alloc_ready), 80'(exp_ready));
    checkOutput("alloc_idx", 80'(alloc_idx), 80'(next_slot()));
    if (n == 0) begin
      checkOutput("head_load", 80'(head_load), 80'(0));
      checkOutput("head_ready", 80'(head_ready), 80'(0));
      checkOutput("mem_out_empty", 80'(mem_out), 80'(0));
    end else begin
      checkOutput("head_load", 80'(head_load), 80'(q[0].is_load));
      checkOutput("head_ready", 80'(head_ready), 80'(q[0].addr_valid && q[0].data_valid));
      checkOutput("mem_rob", 80'(mem_out.ROB_entry), 80'(q[0].rob));
      if (q[0].addr_valid) checkOutput("mem_addr", 80'(mem_out.address), 80'(q[0].address));
      if (q[0].data_valid) checkOutput("mem_result", 80'(mem_out.result), 80'(q[0].data));
    end
  endtask

  task automatic model_update();
    int     n;
    int     k;
    bit     accept;
    bit     cdb_hit;
    entry_t e;
    n = q.size();
    accept = alloc_valid && ((n < DEPTH) || (FULL_EN && rd_en));
    if (flush) begin
      q.delete();
      return;
    end
    if (cdb_valid) begin
      foreach (q[j]) begin
        if (!q[j].is_load && !q[j].data_valid && q[j].data_tag == cdb_rob_entry) begin
          q[j].data_valid = 1'b1;
          q[j].data       = cdb_result;
        end
      end
    end
    if (agu_valid) begin
      k = (int'(agu_idx) - head_slot + DEPTH) % DEPTH;
      if (k < n) begin
        q[k].addr_valid = 1'b1;
        q[k].address    = agu_address;
      end
    end
    if (rd_en && n > 0) begin
      void'(q.pop_front());
      head_slot = (head_slot + 1) % DEPTH;
    end
    if (accept) begin
      cdb_hit      = cdb_valid && !alloc_is_load && !alloc_data_ready && (alloc_data_tag == cdb_rob_entry);
      e.is_load    = alloc_is_load;
      e.rob        = alloc_rob_entry;
      e.addr_valid = 1'b0;
      e.address    = '0;
      e.data_valid = alloc_is_load || alloc_data_ready || cdb_hit;
      e.data       = cdb_hit ? cdb_result : alloc_data;
      e.data_tag   = alloc_data_tag;
      q.push_back(e);
    end
  endtask

  // One clock: compare outputs with the inputs already applied, clock, advance the model, go idle.
  task automatic applyStimulus();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    head_slot = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) begin
      rd_en = 1'b1;
      applyStimulus();
    end
  endtask

  initial begin
    logic [IDX_W-1:0] slot;
    do_reset();
    checkOutput("reset_alloc_ready", 80'(alloc_ready), 80'(1));
    checkOutput("reset_alloc_idx", 80'(alloc_idx), 80'(0));
    checkOutput("reset_count", 80'(count), 80'(0));
    checkOutput("reset_mem_out", 80'(mem_out), 80'(0));

    // Load rob 3, address 0x100, then dequeue.
    alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_rob_entry = 4'd3;
    applyStimulus();
    agu_valid = 1'b1; agu_idx = 3'd0; agu_address = 32'h100;
    applyStimulus();
    checkOutput("tp1_head_load", 80'(head_load), 80'(1));
    checkOutput("tp1_head_ready", 80'(head_ready), 80'(1));
    checkOutput("tp1_addr", 80'(mem_out.address), 80'(32'h100));
    checkOutput("tp1_rob", 80'(mem_out.ROB_entry), 80'(3));
    rd_en = 1'b1;
    applyStimulus();
    checkOutput("tp1_count", 80'(count), 80'(0));
    checkOutput("tp1_head_ready_after", 80'(head_ready), 80'(0));

    // Store waiting on tag 2, resolved by CDB.
    slot = next_slot();
    alloc_valid = 1'b1; alloc_rob_entry = 4'd5; alloc_data_tag = 4'd2;
    applyStimulus();
    agu_valid = 1'b1; agu_idx = slot; agu_address = 32'h40;
    applyStimulus();
    checkOutput("tp2_not_ready", 80'(head_ready), 80'(0));
    cdb_valid = 1'b1; cdb_rob_entry = 4'd2; cdb_result = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("tp2_ready", 80'(head_ready), 80'(1));
    checkOutput("tp2_result", 80'(mem_out.result), 80'(32'hDEADBEEF));
    checkOutput("tp2_head_load", 80'(head_load), 80'(0));
    drain();

    // Fill, then dequeue and allocate together while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_rob_entry = 4'(i);
      applyStimulus();
    end
    checkOutput("full_alloc_ready", 80'(alloc_ready), 80'(0));
    checkOutput("full_count", 80'(count), 80'(8));
    alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_rob_entry = 4'hA; rd_en = 1'b1;
    applyStimulus();
    checkOutput("full_deq_count", 80'(count), 80'(FULL_EN ? 8 : 7));
    checkOutput("full_deq_ready", 80'(alloc_ready), 80'(FULL_EN ? 0 : 1));
    drain();

    // Wrap-around with alternating allocate / dequeue.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_rob_entry = 4'(i);
      end else begin
        rd_en = 1'b1;
      end
      applyStimulus();
    end

    // Flush with concurrent allocate and dequeue.
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_is_load = 1'b0; alloc_data_ready = 1'b1;
      alloc_rob_entry = 4'(i + 8); alloc_data = 32'(i);
      applyStimulus();
    end
    flush = 1'b1; alloc_valid = 1'b1; rd_en = 1'b1; alloc_rob_entry = 4'hF;
    applyStimulus();
    checkOutput("flush_count", 80'(count), 80'(0));
    checkOutput("flush_head_ready", 80'(head_ready), 80'(0));
    checkOutput("flush_alloc_ready", 80'(alloc_ready), 80'(1));
    alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_rob_entry = 4'd1;
    applyStimulus();
    checkOutput("post_flush_count", 80'(count), 80'(1));
    drain();

    // Store capturing its data from a CDB broadcast in the allocation cycle.
    slot = next_slot();
    alloc_valid = 1'b1; alloc_rob_entry = 4'd6; alloc_data_tag = 4'd7;
    cdb_valid = 1'b1; cdb_rob_entry = 4'd7; cdb_result = 32'h1234;
    applyStimulus();
    agu_valid = 1'b1; agu_idx = slot; agu_address = 32'h80;
    applyStimulus();
    checkOutput("same_cycle_ready", 80'(head_ready), 80'(1));
    checkOutput("same_cycle_data", 80'(mem_out.result), 80'(32'h1234));
    drain();

    // Random traffic in phases biased toward filling, draining and balance.
    for (int c = 0; c < 3000; c++) begin
      int phase;
      int p_alloc;
      int p_rd;
      phase   = (c / 150) % 3;
      p_alloc = (phase == 0) ? 85 : ((phase == 1) ? 20 : 50);
      p_rd    = (phase == 0) ? 15 : ((phase == 1) ? 80 : 50);
      alloc_valid      = ($urandom_range(99) < p_alloc);
      alloc_is_load    = $urandom_range(1) == 1;
      alloc_rob_entry  = 4'($urandom_range(15));
      alloc_data_ready = $urandom_range(1) == 1;
      alloc_data       = $urandom;
      alloc_data_tag   = 4'($urandom_range(15));
      rd_en            = ($urandom_range(99) < p_rd);
      agu_valid        = $urandom_range(1) == 1;
      if (q.size() > 0 && $urandom_range(3) != 0)
        agu_idx = IDX_W'((head_slot + int'($urandom_range(q.size() - 1))) % DEPTH);
      else
        agu_idx = IDX_W'($urandom_range(DEPTH - 1));
      agu_address      = $urandom;
      cdb_valid        = $urandom_range(1) == 1;
      cdb_rob_entry    = 4'($urandom_range(15));
      cdb_result       = $urandom;
      flush            = ($urandom_range(59) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
